// File: rtl/cl_axi_pkg.sv
// Shared AXI constants for the CL AXI path: bus widths, response codes and limiter defaults.
// Pure declarations; no timing or flow control of its own.
package cl_axi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  localparam int MAX_WR_OUT_DFLT  = 16;
  localparam int MAX_RD_OUT_DFLT  = 16;
  localparam int TIMEOUT_CYC_DFLT = 4096;

  function automatic int cnt_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/axi_bus_t.sv
// AXI4 bundle; modport names the agent the port faces ("master" = port facing an upstream master).
// Wires only: no latency, backpressure is whatever the endpoints do with valid/ready.
interface axi_bus_t;
  import cl_axi_pkg::*;

  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic                    awvalid;
  logic                    awready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [AXI_ID_W-1:0]     bid;
  axi_resp_e               bresp;
  logic                    bvalid;
  logic                    bready;
  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic                    arvalid;
  logic                    arready;
  logic [AXI_ID_W-1:0]     rid;
  logic [AXI_DATA_W-1:0]   rdata;
  axi_resp_e               rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    input  awid, awaddr, awlen, awsize, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport slave (
    output awid, awaddr, awlen, awsize, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );

endinterface

// File: rtl/cl_axi_txn_ctr.sv
// One-direction address gate, outstanding counter and stall watchdog.
// Zero-latency gate: valid/ready pass combinationally unless full or quiesced (a presented valid is never withdrawn).
module cl_axi_txn_ctr #(
  parameter int MAX_OUT     = 16,
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             quiesce,
  input  logic             clr_err,
  input  logic             s_vld,
  output logic             s_rdy,
  output logic             m_vld,
  input  logic             m_rdy,
  input  logic             cpl,
  output logic [CNT_W-1:0] cnt,
  output logic             pend,
  output logic             timeout
);

  localparam int               WD_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic            full;
  logic            pass;
  logic            hs;
  logic            dec;
  logic            expire;
  logic [WD_W-1:0] wd;

  assign full   = (cnt == MAX_CNT);
  // pend overrides full/quiesce so an address already shown downstream stays valid
  assign pass   = rst_n && ((!full && !quiesce) || pend);
  assign m_vld  = s_vld && pass;
  assign s_rdy  = m_rdy && pass;
  assign hs     = m_vld && m_rdy;
  assign dec    = cpl && (cnt != '0);
  assign expire = (wd == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pend    <= 1'b0;
      wd      <= '0;
      timeout <= 1'b0;
    end else begin
      pend <= m_vld && !m_rdy;

      if (hs && !dec) begin
        cnt <= cnt + CNT_W'(1);
      end else if (!hs && dec) begin
        cnt <= cnt - CNT_W'(1);
      end

      if ((cnt == '0) || cpl) begin
        wd <= '0;
      end else if (!expire) begin
        wd <= wd + WD_W'(1);
      end

      if (expire) begin
        timeout <= 1'b1;
      end else if (clr_err) begin
        timeout <= 1'b0;
      end
    end
  end

  underflow_chk: assert property (@(posedge clk) disable iff (!rst_n) !(cpl && (cnt == '0)));

endmodule

// File: rtl/cl_axi_txn_limiter.sv
// Caps outstanding AXI writes/reads, supports quiesce, and flags stalled directions.
// Zero latency on all channels; only AW/AR valid/ready are gated, W/B/R are straight wires.
module cl_axi_txn_limiter
  import cl_axi_pkg::*;
#(
  parameter int MAX_WR_OUT  = MAX_WR_OUT_DFLT,
  parameter int MAX_RD_OUT  = MAX_RD_OUT_DFLT,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DFLT,
  parameter int CNT_W       = cnt_w(MAX_WR_OUT, MAX_RD_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  axi_bus_t.master         s_axi_bus,
  axi_bus_t.slave          m_axi_bus,
  input  logic             quiesce,
  input  logic             clr_err,
  output logic             idle,
  output logic [CNT_W-1:0] wr_out_cnt,
  output logic [CNT_W-1:0] rd_out_cnt,
  output logic             wr_timeout,
  output logic             rd_timeout
);

  logic wr_cpl;
  logic rd_cpl;
  logic aw_pend;
  logic ar_pend;

  assign m_axi_bus.awid   = s_axi_bus.awid;
  assign m_axi_bus.awaddr = s_axi_bus.awaddr;
  assign m_axi_bus.awlen  = s_axi_bus.awlen;
  assign m_axi_bus.awsize = s_axi_bus.awsize;

  assign m_axi_bus.wdata  = s_axi_bus.wdata;
  assign m_axi_bus.wstrb  = s_axi_bus.wstrb;
  assign m_axi_bus.wlast  = s_axi_bus.wlast;
  assign m_axi_bus.wvalid = s_axi_bus.wvalid;
  assign s_axi_bus.wready = m_axi_bus.wready;

  assign s_axi_bus.bid    = m_axi_bus.bid;
  assign s_axi_bus.bresp  = m_axi_bus.bresp;
  assign s_axi_bus.bvalid = m_axi_bus.bvalid;
  assign m_axi_bus.bready = s_axi_bus.bready;

  assign m_axi_bus.arid   = s_axi_bus.arid;
  assign m_axi_bus.araddr = s_axi_bus.araddr;
  assign m_axi_bus.arlen  = s_axi_bus.arlen;
  assign m_axi_bus.arsize = s_axi_bus.arsize;

  assign s_axi_bus.rid    = m_axi_bus.rid;
  assign s_axi_bus.rdata  = m_axi_bus.rdata;
  assign s_axi_bus.rresp  = m_axi_bus.rresp;
  assign s_axi_bus.rlast  = m_axi_bus.rlast;
  assign s_axi_bus.rvalid = m_axi_bus.rvalid;
  assign m_axi_bus.rready = s_axi_bus.rready;

  // a read retires only on its last beat
  assign wr_cpl = m_axi_bus.bvalid && m_axi_bus.bready;
  assign rd_cpl = m_axi_bus.rvalid && m_axi_bus.rready && m_axi_bus.rlast;

  cl_axi_txn_ctr #(
    .MAX_OUT     (MAX_WR_OUT),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_wr_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .quiesce (quiesce),
    .clr_err (clr_err),
    .s_vld   (s_axi_bus.awvalid),
    .s_rdy   (s_axi_bus.awready),
    .m_vld   (m_axi_bus.awvalid),
    .m_rdy   (m_axi_bus.awready),
    .cpl     (wr_cpl),
    .cnt     (wr_out_cnt),
    .pend    (aw_pend),
    .timeout (wr_timeout)
  );

  cl_axi_txn_ctr #(
    .MAX_OUT     (MAX_RD_OUT),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_rd_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .quiesce (quiesce),
    .clr_err (clr_err),
    .s_vld   (s_axi_bus.arvalid),
    .s_rdy   (s_axi_bus.arready),
    .m_vld   (m_axi_bus.arvalid),
    .m_rdy   (m_axi_bus.arready),
    .cpl     (rd_cpl),
    .cnt     (rd_out_cnt),
    .pend    (ar_pend),
    .timeout (rd_timeout)
  );

  assign idle = (wr_out_cnt == '0) && (rd_out_cnt == '0) && !aw_pend && !ar_pend;

endmodule

// File: tb/tb_cl_axi_txn_limiter.sv
// Directed bench for cl_axi_txn_limiter: limits, quiesce, burst counting, watchdog and async reset.
module tb_cl_axi_txn_limiter;
  import cl_axi_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       quiesce;
  logic       clr_err;
  logic       idle;
  logic [4:0] wr_out_cnt;
  logic [4:0] rd_out_cnt;
  logic       wr_timeout;
  logic       rd_timeout;

  int errors = 0;
  int checks = 0;
  int hs_cnt;
  int lo_cnt;
  int first_lo;

  axi_bus_t s_bus ();
  axi_bus_t m_bus ();

  always #5 clk = ~clk;

  cl_axi_txn_limiter #(
    .MAX_WR_OUT  (16),
    .MAX_RD_OUT  (16),
    .TIMEOUT_CYC (16),
    .CNT_W       (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_axi_bus  (s_bus),
    .m_axi_bus  (m_bus),
    .quiesce    (quiesce),
    .clr_err    (clr_err),
    .idle       (idle),
    .wr_out_cnt (wr_out_cnt),
    .rd_out_cnt (rd_out_cnt),
    .wr_timeout (wr_timeout),
    .rd_timeout (rd_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic init_inputs();
    quiesce = 1'b0;  clr_err = 1'b0;
    s_bus.awid = '0; s_bus.awaddr = '0; s_bus.awlen = '0; s_bus.awsize = 3'd2; s_bus.awvalid = 1'b0;
    s_bus.wdata = '0; s_bus.wstrb = '1; s_bus.wlast = 1'b1; s_bus.wvalid = 1'b0; s_bus.bready = 1'b0;
    s_bus.arid = '0; s_bus.araddr = '0; s_bus.arlen = '0; s_bus.arsize = 3'd2; s_bus.arvalid = 1'b0;
    s_bus.rready = 1'b0;
    m_bus.awready = 1'b0; m_bus.wready = 1'b0; m_bus.bid = '0; m_bus.bresp = RESP_OKAY;
    m_bus.bvalid = 1'b0; m_bus.arready = 1'b0; m_bus.rid = '0; m_bus.rdata = '0;
    m_bus.rresp = RESP_OKAY; m_bus.rlast = 1'b0; m_bus.rvalid = 1'b0;
  endtask

  task automatic do_reset();
    init_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    init_inputs();
    rst_n = 1'b0;
    s_bus.awvalid = 1'b1; m_bus.awready = 1'b1;
    s_bus.arvalid = 1'b1; m_bus.arready = 1'b1;
    tick();
    check("rst_idle", idle, 1);
    check("rst_wr_cnt", wr_out_cnt, 0);
    check("rst_rd_cnt", rd_out_cnt, 0);
    check("rst_wr_to", wr_timeout, 0);
    check("rst_rd_to", rd_timeout, 0);
    check("rst_m_awvalid", m_bus.awvalid, 0);
    check("rst_s_awready", s_bus.awready, 0);
    check("rst_m_arvalid", m_bus.arvalid, 0);

    // 20 back-to-back writes, no B responses
    do_reset();
    s_bus.awvalid = 1'b1; m_bus.awready = 1'b1;
    hs_cnt = 0; lo_cnt = 0; first_lo = -1;
    for (int i = 0; i < 20; i++) begin
      s_bus.awid = AXI_ID_W'(i);
      #1;
      if (s_bus.awready) hs_cnt++;
      else begin
        lo_cnt++;
        if (first_lo < 0) first_lo = i;
      end
      tick();
    end
    check("full_hs_count", hs_cnt, 16);
    check("full_lo_count", lo_cnt, 4);
    check("full_first_lo", first_lo, 16);
    check("full_wr_cnt", wr_out_cnt, 16);
    check("full_wr_to", wr_timeout, 1);
    check("awid_pass", m_bus.awid, 4'd3);
    m_bus.bvalid = 1'b1; s_bus.bready = 1'b1; m_bus.bid = 4'd5; m_bus.bresp = RESP_SLVERR;
    #1;
    check("b_vld_pass", s_bus.bvalid, 1);
    check("b_rdy_pass", m_bus.bready, 1);
    check("b_id_pass", s_bus.bid, 5);
    check("b_resp_pass", s_bus.bresp, 2);
    tick();
    m_bus.bvalid = 1'b0;
    #1;
    check("refill_awready", s_bus.awready, 1);
    check("refill_cnt_before", wr_out_cnt, 15);
    tick();
    check("refill_cnt", wr_out_cnt, 16);
    check("refill_awready_low", s_bus.awready, 0);

    // simultaneous AW and B at count 15
    s_bus.awvalid = 1'b0; m_bus.bvalid = 1'b1;
    tick();
    s_bus.awvalid = 1'b1;
    #1;
    check("sim_awready", s_bus.awready, 1);
    tick();
    check("sim_cnt", wr_out_cnt, 15);
    check("sim_awready_kept", s_bus.awready, 1);

    // quiesce while an AW is stalled downstream
    do_reset();
    s_bus.awvalid = 1'b1; m_bus.awready = 1'b1;
    tick();
    tick();
    m_bus.awready = 1'b0;
    tick();
    quiesce = 1'b1;
    #1;
    check("q_hold_vld0", m_bus.awvalid, 1);
    tick();
    check("q_hold_vld1", m_bus.awvalid, 1);
    check("q_cnt2", wr_out_cnt, 2);
    m_bus.awready = 1'b1;
    #1;
    check("q_hs", s_bus.awready, 1);
    tick();
    check("q_gated_vld", m_bus.awvalid, 0);
    check("q_gated_rdy", s_bus.awready, 0);
    check("q_cnt3", wr_out_cnt, 3);
    check("q_not_idle", idle, 0);
    m_bus.bvalid = 1'b1; s_bus.bready = 1'b1;
    tick();
    tick();
    tick();
    m_bus.bvalid = 1'b0;
    #1;
    check("q_drained_cnt", wr_out_cnt, 0);
    check("q_idle", idle, 1);
    check("q_still_gated", m_bus.awvalid, 0);
    quiesce = 1'b0;
    #1;
    check("q_released", m_bus.awvalid, 1);

    // 4-beat read burst
    do_reset();
    s_bus.arvalid = 1'b1; m_bus.arready = 1'b1; s_bus.arlen = 8'd3;
    #1;
    check("arlen_pass", m_bus.arlen, 3);
    check("ar_hs", s_bus.arready, 1);
    tick();
    s_bus.arvalid = 1'b0;
    check("rd_cnt_after_ar", rd_out_cnt, 1);
    for (int b = 0; b < 4; b++) begin
      m_bus.rvalid = 1'b1; s_bus.rready = 1'b1;
      m_bus.rlast = (b == 3);
      m_bus.rdata = 32'hA0 + 32'(b);
      #1;
      check("rdata_pass", s_bus.rdata, 32'hA0 + 32'(b));
      tick();
      check("rd_cnt_beat", rd_out_cnt, (b == 3) ? 0 : 1);
    end
    m_bus.rvalid = 1'b0; m_bus.rlast = 1'b0;

    // read watchdog, then set-beats-clear
    do_reset();
    s_bus.arvalid = 1'b1; m_bus.arready = 1'b1;
    tick();
    s_bus.arvalid = 1'b0;
    repeat (15) tick();
    check("rd_to_early", rd_timeout, 0);
    tick();
    check("rd_to_rise", rd_timeout, 1);
    check("wr_to_quiet", wr_timeout, 0);
    m_bus.rvalid = 1'b1; m_bus.rlast = 1'b1; s_bus.rready = 1'b1;
    tick();
    m_bus.rvalid = 1'b0; m_bus.rlast = 1'b0;
    check("rd_to_cnt0", rd_out_cnt, 0);
    check("rd_to_sticky", rd_timeout, 1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("rd_to_cleared", rd_timeout, 0);
    s_bus.arvalid = 1'b1;
    tick();
    s_bus.arvalid = 1'b0;
    repeat (15) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("rd_to_set_wins", rd_timeout, 1);
    m_bus.rvalid = 1'b1; m_bus.rlast = 1'b1;
    tick();
    m_bus.rvalid = 1'b0; m_bus.rlast = 1'b0;

    // async reset with 5 writes outstanding
    do_reset();
    s_bus.awvalid = 1'b1; m_bus.awready = 1'b1;
    repeat (5) tick();
    s_bus.awvalid = 1'b0;
    s_bus.wvalid = 1'b1; m_bus.wready = 1'b1;
    #1;
    check("mid_cnt5", wr_out_cnt, 5);
    check("mid_not_idle", idle, 0);
    check("wvalid_pass", m_bus.wvalid, 1);
    check("wready_pass", s_bus.wready, 1);
    repeat (17) tick();
    check("mid_wr_to", wr_timeout, 1);
    s_bus.awvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", wr_out_cnt, 0);
    check("arst_wr_to", wr_timeout, 0);
    check("arst_idle", idle, 1);
    check("arst_awvalid", m_bus.awvalid, 0);
    tick();
    rst_n = 1'b1;
    init_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cl_axi_txn_limiter.md
Name: cl_axi_txn_limiter

Overview:
- AXI4 stage placed directly upstream of the CL AXI register slice. Its m_axi side feeds the slice's s_axi side.
- Limits outstanding write and read transactions to configurable maxima, and supports a quiesce/drain request for the downstream path.
- Runs a per-direction watchdog that flags transactions that never complete.
- Data, W, B and R channels pass through with zero latency. Only AW and AR valid/ready are gated.

Parameters:
- MAX_WR_OUT, 16: maximum outstanding writes, counted from AW accepted to B accepted. Legal range 1..255.
- MAX_RD_OUT, 16: maximum outstanding reads, counted from AR accepted to R with rlast accepted. Legal range 1..255.
- TIMEOUT_CYC, 4096: cycles without any completion, while outstanding count > 0, before the timeout flag sets. Must be ≥ 2.
- CNT_W, $clog2(max(MAX_WR_OUT,MAX_RD_OUT)+1): width of the outstanding counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axi_bus  axi_bus_t.master modport  -  upstream AXI4 port; this block is the subordinate (slave) on it
- m_axi_bus  axi_bus_t.slave modport  -  downstream AXI4 port, connects to the register slice
- quiesce  in  1  when high, no new AW/AR is accepted; in-flight transactions complete normally
- clr_err  in  1  single-cycle pulse that clears the sticky timeout flags
- idle  out  1  both outstanding counts are 0 and no address is pending downstream
- wr_out_cnt  out  CNT_W  current outstanding writes
- rd_out_cnt  out  CNT_W  current outstanding reads
- wr_timeout  out  1  sticky write watchdog flag
- rd_timeout  out  1  sticky read watchdog flag

Behaviour:
- Reset (async assert, sync deassert handled outside): all counters 0, pending flags 0, wr_timeout/rd_timeout 0, idle 1. The gated valid/ready outputs are 0 while rst_n is low.
- Pass-through: all payload fields (id, addr, len, size, data, strb, last, resp) and the W/B/R valid/ready signals are wired straight through, with no register.
- AW gating:
  - aw_allow = !wr_full && !quiesce, where wr_full = (wr_out_cnt == MAX_WR_OUT).
  - m.awvalid = s.awvalid && (aw_allow || aw_pend).
  - s.awready = m.awready && (aw_allow || aw_pend).
- aw_pend register:
  - Sets when m.awvalid && !m.awready.
  - Clears on the m-side AW handshake.
  - Purpose: once awvalid has been presented downstream it is never withdrawn, even if quiesce rises. This keeps AXI valid-stability.
- AR gating: identical, using rd_full, quiesce and ar_pend.
- Write counter:
  - +1 on AW handshake; −1 on B handshake (bvalid && bready).
  - Both in the same cycle: unchanged.
  - Never exceeds MAX_WR_OUT; never underflows. A B handshake at count 0 is a protocol error: the counter holds 0 and an assertion fires in simulation.
- Read counter:
  - +1 on AR handshake; −1 on R handshake with rlast.
  - R beats without rlast do not change the count.
  - Same simultaneous-event and underflow rules as the write counter.
- Full boundary: at count == MAX−1, an address handshake in cycle N makes the block full in cycle N+1, so valid is gated from N+1 onward. If a completion also occurs in cycle N, the count stays at MAX−1 and the block does not go full.
- Watchdog (per direction):
  - A TIMEOUT_CYC-range counter resets to 0 whenever the outstanding count is 0 or a completion handshake occurs. Otherwise it increments, saturating.
  - When it reaches TIMEOUT_CYC−1, the timeout flag sets the next cycle.
  - The flag is sticky until clr_err. If clr_err and a new expiry occur in the same cycle, set wins.
  - A flag does not block traffic.
- idle = (wr_out_cnt == 0) && (rd_out_cnt == 0) && !aw_pend && !ar_pend. It is combinational from registers.
- Mid-operation reset: everything returns to reset values immediately. Completions still in flight downstream are the integrator's responsibility; downstream is reset in the same domain.

Decomposition:
- Shared package cl_axi_pkg holds:
  - AXI resp encodings (OKAY/SLVERR).
  - The default limits MAX_WR_OUT_DFLT and MAX_RD_OUT_DFLT.
  - The default TIMEOUT_CYC.
- One sub-module, cl_axi_txn_ctr: a parameterised gate + counter + watchdog for one direction. It is instantiated twice, once for write and once for read.

Test Plan:
- Back-to-back 20 single-beat writes with bready held 0, MAX_WR_OUT=16 → exactly 16 AW handshakes accepted, awready stays 0 from the cycle after the 16th. Releasing bready for one B → the next AW is accepted the following cycle; wr_out_cnt reads 16.
- At wr_out_cnt=15, an AW handshake and a B handshake in the same cycle → count stays 15, awready is not dropped.
- Raise quiesce while m.awvalid=1 and m.awready=0 → m.awvalid stays 1 until the handshake. A subsequent AW is held off; idle=1 after all 3 outstanding B responses return.
- 4-beat read burst (arlen=3): rd_out_cnt is 1 after AR and stays 1 through beats 0–2 → 0 after the rlast beat.
- TIMEOUT_CYC=16, one AR issued and R withheld → rd_timeout rises exactly 16 cycles after the AR handshake and stays high after R completes. Pulse clr_err → flag cleared.
- Assert rst_n=0 mid-burst with 5 writes outstanding → wr_out_cnt=0, flags 0, idle=1 in the same cycle (async).
